mem_port_arbiter: RTL and testbench

//  Shares the single data-memory port (read_en/write_en/ready handshake) between two

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one data-memory port between two requesters:
//     port 0 = data-cache controller, port 1 = instruction-fetch refill.
//   One request is latched at a time. The memory is driven with a read or
//   write strobe until mem_ready. The owner then receives a one-cycle done
//   pulse together with the captured read data. Accesses that hang are
//   aborted by a watchdog, which reports them with err.
//
//   Configuration macro: ARB_ROUND_ROBIN_EN
//     defined   - when both ports request in the same cycle, the port that
//                 did not own the previous access wins (port 0 first after
//                 reset).
//     undefined - fixed priority; port 0 always wins.
//
// Ports
//   clk, reset_n              clock (rising edge), asynchronous active-low reset
//   reqN_rd / reqN_wr         level requests, held by port N until doneN
//   reqN_addr / reqN_wdata    address and write data for port N
//   done0 / done1             one-cycle completion pulse per port
//   rdata                     read data, valid while doneN is high after a read
//   err                       one-cycle pulse alongside doneN when the watchdog
//                             aborted the access
//   mem_read_en/mem_write_en  memory strobes, held high for the whole access
//   mem_addr / mem_wdata      latched address and write data for the memory
//   mem_rdata / mem_ready     memory read data and completion
module mem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_rd,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_rd,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              owner, owner_nxt;
  logic              op_wr, op_wr_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              done0_nxt, done1_nxt, err_nxt;
  logic              rd_en_nxt, wr_en_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt, rdata_nxt;
  logic              any0, any1, grant;

  assign any0 = req0_rd | req0_wr;
  assign any1 = req1_rd | req1_wr;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner, last_owner_nxt;

  // Contention goes to the port that did not own the previous access.
  // A single requester is granted directly.
  assign grant = (any0 && any1) ? ~last_owner : ~any0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_owner <= 1'b1;
    else          last_owner <= last_owner_nxt;
  end
`else
  assign grant = ~any0;
`endif

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    op_wr_nxt    = op_wr;
    wait_cnt_nxt = wait_cnt;
    addr_nxt     = mem_addr;
    wdata_nxt    = mem_wdata;
    rdata_nxt    = rdata;
    done0_nxt    = 1'b0;
    done1_nxt    = 1'b0;
    err_nxt      = 1'b0;
    rd_en_nxt    = 1'b0;
    wr_en_nxt    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_nxt = last_owner;
`endif
    unique case (state)
      IDLE: begin
        if (any0 || any1) begin
          owner_nxt    = grant;
          // A write wins over a read when a port raises both.
          op_wr_nxt    = grant ? req1_wr : req0_wr;
          addr_nxt     = grant ? req1_addr : req0_addr;
          wdata_nxt    = grant ? req1_wdata : req0_wdata;
          rd_en_nxt    = ~op_wr_nxt;
          wr_en_nxt    = op_wr_nxt;
          wait_cnt_nxt = '0;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          // Only a read updates rdata; a write leaves the last read data in place.
          if (!op_wr) rdata_nxt = mem_rdata;
          done0_nxt = ~owner;
          done1_nxt = owner;
          state_nxt = RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          // The watchdog fires after MAX_WAIT strobe cycles without mem_ready.
          rdata_nxt = '0;
          err_nxt   = 1'b1;
          done0_nxt = ~owner;
          done1_nxt = owner;
          state_nxt = RESP;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
          rd_en_nxt    = ~op_wr;
          wr_en_nxt    = op_wr;
        end
      end
      RESP: begin
        wait_cnt_nxt = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_nxt = owner;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      op_wr        <= 1'b0;
      wait_cnt     <= '0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err          <= 1'b0;
      rdata        <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      op_wr        <= op_wr_nxt;
      wait_cnt     <= wait_cnt_nxt;
      done0        <= done0_nxt;
      done1        <= done1_nxt;
      err          <= err_nxt;
      rdata        <= rdata_nxt;
      mem_read_en  <= rd_en_nxt;
      mem_write_en <= wr_en_nxt;
      mem_addr     <= addr_nxt;
      mem_wdata    <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (MAX_WAIT = 4). A scoreboard queue holds the
// expected completion of each access; every completion seen is popped and
// compared. Inputs are driven on the falling edge, and outputs are sampled
// there as well.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_rd = 0, req0_wr = 0, req1_rd = 0, req1_wr = 0;
  logic [9:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_wdata = '0, req1_wdata = '0;
  logic        done0, done1, err, mem_read_en, mem_write_en;
  logic [31:0] rdata, mem_wdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic        port;
    logic        wr;
    logic        err;
    logic [9:0]  addr;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rdata = '0;

  // Observed values from the most recent access.
  int          o_scyc;
  logic        o_rd, o_wr, o_d0, o_d1, o_err, o_tmo;
  logic [9:0]  o_addr;
  logic [31:0] o_wdata, o_rdata;
  exp_t        x;
  logic [46:0] obs_v, exp_v;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_rd(req0_rd), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_rd(req1_rd), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .done0(done0), .done1(done1), .rdata(rdata), .err(err),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Queue the expected result of one access and advance the rdata model.
  task automatic push_exp(input logic port, input logic wr, input logic e,
                          input logic [9:0] addr, input logic [31:0] data);
    exp_t t;
    if (e)       model_rdata = '0;
    else if (!wr) model_rdata = data;
    t.port = port; t.wr = wr; t.err = e; t.addr = addr; t.rdata = model_rdata;
    sb.push_back(t);
  endtask

  // Memory model plus requester behaviour for one access. mem_ready is raised
  // in strobe cycle number 'delay' (never if delay < 0). When a done pulse is
  // seen, the owning port drops its request. The observed values are returned.
  task automatic do_access(input int delay, input logic [31:0] data);
    o_scyc = 0; o_rd = 0; o_wr = 0; o_addr = '0; o_wdata = '0;
    o_d0 = 0; o_d1 = 0; o_err = 0; o_rdata = '0; o_tmo = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        o_d0 = done0; o_d1 = done1; o_err = err; o_rdata = rdata; o_tmo = 0;
        mem_ready = 0;
        if (done0) begin req0_rd = 0; req0_wr = 0; end
        if (done1) begin req1_rd = 0; req1_wr = 0; end
        break;
      end
      if (mem_read_en || mem_write_en) begin
        o_scyc++;
        o_rd = o_rd | mem_read_en;
        o_wr = o_wr | mem_write_en;
        o_addr = mem_addr;
        o_wdata = mem_wdata;
        mem_ready = (o_scyc == delay);
        mem_rdata = (o_scyc == delay) ? data : 32'h0;
      end else begin
        mem_ready = 0;
      end
    end
    mem_ready = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({done0, done1, err, mem_read_en, mem_write_en, mem_addr, mem_wdata, rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got d0=%b d1=%b err=%b rd=%b wr=%b addr=%h wd=%h rdata=%h, want all 0",
               done0, done1, err, mem_read_en, mem_write_en, mem_addr, mem_wdata, rdata);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({done0, done1, mem_read_en, mem_write_en} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got %b want 0000", {done0, done1, mem_read_en, mem_write_en});
    end
  endtask

  task automatic test_read;
    req0_addr = 10'h005; req0_rd = 1;
    push_exp(1'b0, 1'b0, 1'b0, 10'h005, 32'hDEADBEEF);
    do_access(2, 32'hDEADBEEF);
    x = sb.pop_front();
    obs_v = {o_d1, o_d0, o_err, o_wr, o_rd, o_addr, o_rdata};
    exp_v = {x.port, ~x.port, x.err, x.wr, ~x.wr, x.addr, x.rdata};
    tests_run++;
    if (o_tmo || obs_v !== exp_v) begin
      tests_failed++;
      $display("FAIL read_done: got %h tmo=%b want %h", obs_v, o_tmo, exp_v);
    end
    tests_run++;
    if (o_scyc !== 2) begin
      tests_failed++;
      $display("FAIL read_strobe_len: got %0d want 2", o_scyc);
    end
    @(negedge clk);
    tests_run++;
    if ({done0, done1} !== 2'b00) begin
      tests_failed++;
      $display("FAIL done_one_cycle: got %b want 00", {done0, done1});
    end
  endtask

  task automatic test_write;
    req1_addr = 10'h3FF; req1_wdata = 32'h12345678; req1_wr = 1;
    push_exp(1'b1, 1'b1, 1'b0, 10'h3FF, 32'h0);
    do_access(1, 32'h55AA55AA);
    x = sb.pop_front();
    obs_v = {o_d1, o_d0, o_err, o_wr, o_rd, o_addr, o_rdata};
    exp_v = {x.port, ~x.port, x.err, x.wr, ~x.wr, x.addr, x.rdata};
    tests_run++;
    if (o_tmo || obs_v !== exp_v) begin
      tests_failed++;
      $display("FAIL write_done: got %h tmo=%b want %h", obs_v, o_tmo, exp_v);
    end
    tests_run++;
    if (o_scyc !== 1 || o_wdata !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL write_strobe: got cycles=%0d wdata=%h want 1 12345678", o_scyc, o_wdata);
    end
  endtask

  task automatic test_ready_outside_busy;
    mem_ready = 1; mem_rdata = 32'hFFFF0000;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({done0, done1, mem_read_en, mem_write_en} !== 4'b0 || rdata !== model_rdata) begin
      tests_failed++;
      $display("FAIL ready_idle: got ctl=%b rdata=%h want 0000 %h",
               {done0, done1, mem_read_en, mem_write_en}, rdata, model_rdata);
    end
    mem_ready = 0;
    @(negedge clk);
  endtask

  task automatic test_arbitration;
    int n;
`ifdef ARB_ROUND_ROBIN_EN
    n = 4;
    push_exp(1'b0, 1'b0, 1'b0, 10'h010, 32'hA0000000);
    push_exp(1'b1, 1'b0, 1'b0, 10'h011, 32'hA0000001);
    push_exp(1'b0, 1'b0, 1'b0, 10'h012, 32'hA0000002);
    push_exp(1'b1, 1'b0, 1'b0, 10'h013, 32'hA0000003);
`else
    n = 3;
    push_exp(1'b0, 1'b0, 1'b0, 10'h010, 32'hA0000000);
    push_exp(1'b0, 1'b0, 1'b0, 10'h012, 32'hA0000001);
    push_exp(1'b1, 1'b0, 1'b0, 10'h011, 32'hA0000002);
`endif
    req0_addr = 10'h010; req0_rd = 1;
    req1_addr = 10'h011; req1_rd = 1;
    for (int i = 0; i < n; i++) begin
      do_access(1, 32'hA0000000 + i);
      x = sb.pop_front();
      obs_v = {o_d1, o_d0, o_err, o_wr, o_rd, o_addr, o_rdata};
      exp_v = {x.port, ~x.port, x.err, x.wr, ~x.wr, x.addr, x.rdata};
      tests_run++;
      if (o_tmo || obs_v !== exp_v) begin
        tests_failed++;
        $display("FAIL arb_access%0d: got %h tmo=%b want %h", i, obs_v, o_tmo, exp_v);
      end
      // Re-raise requests so that both ports contend again.
      if (i == 0) begin req0_addr = 10'h012; req0_rd = 1; end
`ifdef ARB_ROUND_ROBIN_EN
      if (i == 1) begin req1_addr = 10'h013; req1_rd = 1; end
`endif
    end
  endtask

  task automatic test_watchdog;
    req0_addr = 10'h021; req0_rd = 1;
    push_exp(1'b0, 1'b0, 1'b1, 10'h021, 32'h0);
    do_access(-1, 32'h0);
    x = sb.pop_front();
    obs_v = {o_d1, o_d0, o_err, o_wr, o_rd, o_addr, o_rdata};
    exp_v = {x.port, ~x.port, x.err, x.wr, ~x.wr, x.addr, x.rdata};
    tests_run++;
    if (o_tmo || obs_v !== exp_v) begin
      tests_failed++;
      $display("FAIL watchdog_done: got %h tmo=%b want %h", obs_v, o_tmo, exp_v);
    end
    tests_run++;
    if (o_scyc !== 4) begin
      tests_failed++;
      $display("FAIL watchdog_len: got %0d want 4", o_scyc);
    end
    req0_addr = 10'h022; req0_rd = 1;
    push_exp(1'b0, 1'b0, 1'b0, 10'h022, 32'hCAFEF00D);
    do_access(3, 32'hCAFEF00D);
    x = sb.pop_front();
    obs_v = {o_d1, o_d0, o_err, o_wr, o_rd, o_addr, o_rdata};
    exp_v = {x.port, ~x.port, x.err, x.wr, ~x.wr, x.addr, x.rdata};
    tests_run++;
    if (o_tmo || obs_v !== exp_v || o_scyc !== 3) begin
      tests_failed++;
      $display("FAIL after_watchdog: got %h cyc=%0d tmo=%b want %h cyc=3", obs_v, o_scyc, o_tmo, exp_v);
    end
  endtask

  task automatic test_rd_wr_both;
    req0_addr = 10'h030; req0_wdata = 32'h0F0F0F0F; req0_rd = 1; req0_wr = 1;
    push_exp(1'b0, 1'b1, 1'b0, 10'h030, 32'h0);
    do_access(2, 32'h77777777);
    x = sb.pop_front();
    obs_v = {o_d1, o_d0, o_err, o_wr, o_rd, o_addr, o_rdata};
    exp_v = {x.port, ~x.port, x.err, x.wr, ~x.wr, x.addr, x.rdata};
    tests_run++;
    if (o_tmo || obs_v !== exp_v || o_wdata !== 32'h0F0F0F0F) begin
      tests_failed++;
      $display("FAIL rd_wr_both: got %h wd=%h tmo=%b want %h wd=0f0f0f0f", obs_v, o_wdata, o_tmo, exp_v);
    end
  endtask

  task automatic test_reset_mid;
    req1_addr = 10'h033; req1_rd = 1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (mem_read_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_busy: got rd_en=%b want 1", mem_read_en);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({done0, done1, err, mem_read_en, mem_write_en, mem_addr, mem_wdata, rdata} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got rd=%b wr=%b addr=%h wd=%h rdata=%h want all 0",
               mem_read_en, mem_write_en, mem_addr, mem_wdata, rdata);
    end
    model_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    push_exp(1'b1, 1'b0, 1'b0, 10'h033, 32'h0BADCAFE);
    do_access(1, 32'h0BADCAFE);
    x = sb.pop_front();
    obs_v = {o_d1, o_d0, o_err, o_wr, o_rd, o_addr, o_rdata};
    exp_v = {x.port, ~x.port, x.err, x.wr, ~x.wr, x.addr, x.rdata};
    tests_run++;
    if (o_tmo || obs_v !== exp_v) begin
      tests_failed++;
      $display("FAIL midreset_regrant: got %h tmo=%b want %h", obs_v, o_tmo, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_ready_outside_busy();
    test_arbitration();
    test_watchdog();
    test_rd_wr_both();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
